// File: rtl/sram_access_arbiter.sv
// Two-requester arbiter for the single async SRAM frame buffer: display reads have priority,
// the walker is forced in after STARVE_MAX consecutive display grants; all outputs registered.
module sram_access_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iDisp_req,
  input  logic [ADDR_W-1:0] iDisp_addr,
  output logic [DATA_W-1:0] oDisp_data,
  output logic              oDisp_valid,
  input  logic              iWlk_req,
  input  logic              iWlk_we,
  input  logic [ADDR_W-1:0] iWlk_addr,
  input  logic [DATA_W-1:0] iWlk_wdata,
  output logic              oWlk_ack,
  output logic [DATA_W-1:0] oWlk_rdata,
  output logic              oWlk_rvalid,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  output logic [DATA_W-1:0] oSRAM_DQ_OUT,
  output logic              oSRAM_DQ_OE,
  input  logic [DATA_W-1:0] iSRAM_DQ_IN,
  output logic              oSRAM_WE_N,
  output logic              oSRAM_OE_N,
  output logic [1:0]        oOwner
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_DISP = 3'd1,
    RD_WLK  = 3'd2,
    WR_WLK  = 3'd3,
    WR_TURN = 3'd4
  } state_t;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t              state_q, state_d;
  logic [3:0]          starve_q, starve_d;
  logic [1:0]          owner_q, owner_d;
  logic                ack_q, ack_d;
  logic                disp_vld_q, disp_vld_d;
  logic                wlk_rvld_q, wlk_rvld_d;
  logic [DATA_W-1:0]   disp_data_q, disp_data_d;
  logic [DATA_W-1:0]   wlk_rdata_q, wlk_rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   dq_out_q, dq_out_d;
  logic                dq_oe_q, dq_oe_d;
  logic                we_n_q, we_n_d;
  logic                oe_n_q, oe_n_d;
  logic                wlk_elig;

  // A request still high during its own ack cycle must not be granted twice.
  assign wlk_elig = iWlk_req & ~ack_q;

  always_comb begin
    state_d     = state_q;
    starve_d    = wlk_elig ? starve_q : 4'd0;
    ack_d       = 1'b0;
    disp_vld_d  = 1'b0;
    wlk_rvld_d  = 1'b0;
    disp_data_d = disp_data_q;
    wlk_rdata_d = wlk_rdata_q;
    addr_d      = addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = 1'b0;
    we_n_d      = 1'b1;
    oe_n_d      = 1'b1;

    if (state_q == RD_DISP) begin
      disp_data_d = iSRAM_DQ_IN;
      disp_vld_d  = 1'b1;
    end
    if (state_q == RD_WLK) begin
      wlk_rdata_d = iSRAM_DQ_IN;
      wlk_rvld_d  = 1'b1;
    end

    if (state_q == WR_WLK) begin
      state_d = WR_TURN;
    end else if (wlk_elig && (starve_q == STARVE_LIM || !iDisp_req)) begin
      starve_d = 4'd0;
      ack_d    = 1'b1;
      addr_d   = iWlk_addr;
      if (iWlk_we) begin
        state_d  = WR_WLK;
        dq_out_d = iWlk_wdata;
        dq_oe_d  = 1'b1;
        we_n_d   = 1'b0;
      end else begin
        state_d = RD_WLK;
        oe_n_d  = 1'b0;
      end
    end else if (iDisp_req) begin
      state_d = RD_DISP;
      addr_d  = iDisp_addr;
      oe_n_d  = 1'b0;
      if (wlk_elig && starve_q != STARVE_LIM) starve_d = starve_q + 4'd1;
    end else begin
      state_d = IDLE;
    end

    owner_d = (state_d == WR_TURN) ? 2'b11 : state_d[1:0];
  end

  // Async reset drops WE_N/DQ_OE immediately, even in the middle of a write.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state_q     <= IDLE;
      starve_q    <= 4'd0;
      owner_q     <= 2'b00;
      ack_q       <= 1'b0;
      disp_vld_q  <= 1'b0;
      wlk_rvld_q  <= 1'b0;
      disp_data_q <= '0;
      wlk_rdata_q <= '0;
      addr_q      <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      owner_q     <= owner_d;
      ack_q       <= ack_d;
      disp_vld_q  <= disp_vld_d;
      wlk_rvld_q  <= wlk_rvld_d;
      disp_data_q <= disp_data_d;
      wlk_rdata_q <= wlk_rdata_d;
      addr_q      <= addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
    end
  end

  assign oDisp_data   = disp_data_q;
  assign oDisp_valid  = disp_vld_q;
  assign oWlk_ack     = ack_q;
  assign oWlk_rdata   = wlk_rdata_q;
  assign oWlk_rvalid  = wlk_rvld_q;
  assign oSRAM_ADDR   = addr_q;
  assign oSRAM_DQ_OUT = dq_out_q;
  assign oSRAM_DQ_OE  = dq_oe_q;
  assign oSRAM_WE_N   = we_n_q;
  assign oSRAM_OE_N   = oe_n_q;
  assign oOwner       = owner_q;

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Directed bench for sram_access_arbiter with a one-location SRAM model that
// otherwise returns addr[15:0] as read data.
module tb_sram_access_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        disp_req = 1'b0;
  logic [19:0] disp_addr = '0;
  logic [15:0] disp_data;
  logic        disp_vld;
  logic        wlk_req = 1'b0;
  logic        wlk_we = 1'b0;
  logic [19:0] wlk_addr = '0;
  logic [15:0] wlk_wdata = '0;
  logic        wlk_ack;
  logic [15:0] wlk_rdata;
  logic        wlk_rvld;
  logic [19:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_we_n;
  logic        sram_oe_n;
  logic [1:0]  owner;

  int n_chk  = 0;
  int n_fail = 0;

  logic [19:0] m_addr = '0;
  logic [15:0] m_data = '0;
  logic        m_vld  = 1'b0;

  localparam logic [19:0] WADDR = {10'd80, 10'd200};

  sram_access_arbiter #(.ADDR_W(20), .DATA_W(16), .STARVE_MAX(4)) dut (
    .iCLK(clk), .iRST(rst),
    .iDisp_req(disp_req), .iDisp_addr(disp_addr), .oDisp_data(disp_data), .oDisp_valid(disp_vld),
    .iWlk_req(wlk_req), .iWlk_we(wlk_we), .iWlk_addr(wlk_addr), .iWlk_wdata(wlk_wdata),
    .oWlk_ack(wlk_ack), .oWlk_rdata(wlk_rdata), .oWlk_rvalid(wlk_rvld),
    .oSRAM_ADDR(sram_addr), .oSRAM_DQ_OUT(sram_dq_out), .oSRAM_DQ_OE(sram_dq_oe),
    .iSRAM_DQ_IN(sram_dq_in), .oSRAM_WE_N(sram_we_n), .oSRAM_OE_N(sram_oe_n), .oOwner(owner)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!sram_we_n) begin
      m_addr = sram_addr;
      m_data = sram_dq_out;
      m_vld  = 1'b1;
    end
  end

  assign sram_dq_in = (m_vld && m_addr == sram_addr) ? m_data : sram_addr[15:0];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int acks;
    int rd_wlk_cnt;

    // Reset values
    repeat (3) @(posedge clk);
    #2;
    chk("rst_we_n", sram_we_n, 1);
    chk("rst_oe_n", sram_oe_n, 1);
    chk("rst_dq_oe", sram_dq_oe, 0);
    chk("rst_addr", sram_addr, 0);
    chk("rst_dq_out", sram_dq_out, 0);
    chk("rst_owner", owner, 0);
    chk("rst_valids", {disp_vld, wlk_ack, wlk_rvld}, 0);
    chk("rst_data", {disp_data, wlk_rdata}, 0);
    rst = 1'b0;

    // Display stream 0x00..0x0F
    @(posedge clk); #1;
    disp_req  = 1'b1;
    disp_addr = 20'd0;
    for (int k = 0; k <= 16; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        chk("disp_first_novld", disp_vld, 0);
        chk("disp_owner", owner, 1);
        chk("disp_oe_n", sram_oe_n, 0);
      end else begin
        chk("disp_vld", disp_vld, 1);
        chk("disp_data", disp_data, k - 1);
      end
      if (k + 1 < 16) disp_addr = 20'(k + 1);
      else disp_req = 1'b0;
    end
    @(posedge clk); #1;
    chk("disp_end_vld", disp_vld, 0);
    chk("disp_end_owner", owner, 0);
    chk("idle_oe_n", sram_oe_n, 1);

    // Walker write then read of the same location
    wlk_req   = 1'b1;
    wlk_we    = 1'b1;
    wlk_addr  = WADDR;
    wlk_wdata = 16'hFFFF;
    @(posedge clk); #1;
    chk("wr_owner", owner, 3);
    chk("wr_ack", wlk_ack, 1);
    chk("wr_we_n", sram_we_n, 0);
    chk("wr_dq_oe", sram_dq_oe, 1);
    chk("wr_addr", sram_addr, WADDR);
    chk("wr_dq_out", sram_dq_out, 16'hFFFF);
    wlk_we    = 1'b0;
    wlk_wdata = 16'h0000;
    @(posedge clk); #1;
    chk("turn_owner", owner, 3);
    chk("turn_we_n", sram_we_n, 1);
    chk("turn_dq_oe", sram_dq_oe, 0);
    chk("turn_oe_n", sram_oe_n, 1);
    chk("turn_ack", wlk_ack, 0);
    chk("turn_addr", sram_addr, WADDR);
    @(posedge clk); #1;
    chk("rdw_owner", owner, 2);
    chk("rdw_ack", wlk_ack, 1);
    chk("rdw_oe_n", sram_oe_n, 0);
    @(posedge clk); #1;
    chk("rdw_rvld", wlk_rvld, 1);
    chk("rdw_rdata", wlk_rdata, 16'hFFFF);
    chk("rdw_ack_drop", wlk_ack, 0);
    chk("rdw_idle", owner, 0);
    wlk_req = 1'b0;
    @(posedge clk); #1;
    chk("rdw_rvld_pulse", wlk_rvld, 0);

    // Contention: both read requests held continuously
    disp_req  = 1'b1;
    disp_addr = 20'd5;
    wlk_req   = 1'b1;
    wlk_we    = 1'b0;
    wlk_addr  = 20'd7;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      chk("cont_owner", owner, (k < 5) ? 1 : 2);
    end
    acks = 0;
    for (int k = 6; k <= 11; k++) begin
      @(posedge clk); #1;
      if (k == 6) begin
        chk("cont_rvld", wlk_rvld, 1);
        chk("cont_rdata", wlk_rdata, 16'h0007);
        chk("cont_disp_after_w", owner, 1);
      end
      if (wlk_ack) acks++;
    end
    chk("cont_acks", acks, 1);
    disp_req = 1'b0;
    wlk_req  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("cont_idle", owner, 0);

    // No double grant when walker request outlives the ack cycle
    wlk_req  = 1'b1;
    wlk_addr = 20'h00123;
    rd_wlk_cnt = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (owner == 2'd2) rd_wlk_cnt++;
      if (k == 1) begin
        chk("ndg_rvld", wlk_rvld, 1);
        chk("ndg_rdata", wlk_rdata, 16'h0123);
        wlk_req = 1'b0;
      end
    end
    chk("ndg_one_grant", rd_wlk_cnt, 1);
    chk("ndg_starve", dut.starve_q, 0);

    // Reset asserted in the middle of a write cycle
    wlk_req   = 1'b1;
    wlk_we    = 1'b1;
    wlk_addr  = 20'h00055;
    wlk_wdata = 16'hA5A5;
    @(posedge clk); #1;
    chk("rwr_we_n_low", sram_we_n, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("rwr_we_n", sram_we_n, 1);
    chk("rwr_dq_oe", sram_dq_oe, 0);
    chk("rwr_owner", owner, 0);
    chk("rwr_ack", wlk_ack, 0);
    chk("rwr_addr", sram_addr, 0);
    wlk_req = 1'b0;
    wlk_we  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("post_rst_idle", owner, 0);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
